// File: rtl/led_bus_pkg.sv
// Shared state/owner types and parameter defaults for the LED serial-bus sequencer.
package led_bus_pkg;

  typedef enum logic [2:0] {
    ST_INIT_START,
    ST_INIT_WAIT,
    ST_GUARD,
    ST_IDLE,
    ST_FRAME
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_FRAME
  } owner_t;

  localparam int DEF_GUARD_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

endpackage

// File: rtl/led_bus_mux.sv
// Registered three-line bus mux: every line sees the same single-cycle delay
// from the selected owner's drive to the LED-driver pins.
module led_bus_mux
  import led_bus_pkg::*;
(
  input  logic       spiClk,
  input  logic       reset,
  input  logic [1:0] owner,
  input  logic       initLat,
  input  logic       initSdo,
  input  logic       initSclk,
  input  logic       frameLat,
  input  logic       frameSdo,
  input  logic       frameSclk,
  output logic       LAT,
  output logic       SDOsingle,
  output logic       SCLK
);

  // The pins must fall to idle on the cycle after reset, so the bus registers are reset too.
  always_ff @(posedge spiClk) begin
    if (reset) begin
      LAT       <= 1'b0;
      SDOsingle <= 1'b0;
      SCLK      <= 1'b0;
    end else begin
      unique case (owner)
        OWN_INIT: begin
          LAT       <= initLat;
          SDOsingle <= initSdo;
          SCLK      <= initSclk;
        end
        OWN_FRAME: begin
          LAT       <= frameLat;
          SDOsingle <= frameSdo;
          SCLK      <= frameSclk;
        end
        default: begin
          LAT       <= 1'b0;
          SDOsingle <= 1'b0;
          SCLK      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_bus_sequencer.sv
// Arbitrates the LED-driver serial bus between the init engine and the frame
// shifter, with guard gaps, hang recovery and periodic/host-requested re-init.
module led_bus_sequencer
  import led_bus_pkg::*;
#(
  parameter int REINIT_FRAMES  = 0,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        spiClk,
  input  logic        reset,
  output logic        initStart,
  input  logic        initDone,
  input  logic        initLat,
  input  logic        initSdo,
  input  logic        initSclk,
  input  logic        frameReq,
  output logic        frameGrant,
  input  logic        frameDone,
  input  logic        frameLat,
  input  logic        frameSdo,
  input  logic        frameSclk,
  input  logic        reinitReq,
  output logic        LAT,
  output logic        SDOsingle,
  output logic        SCLK,
  output logic        ready,
  output logic        errTimeout,
  output logic [15:0] frameCount
);

  localparam int              GW           = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0]   GUARD_LAST   = GW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     REINIT_AT    = 16'(REINIT_FRAMES);

  state_t        state, state_next;
  state_t        guard_to, guard_to_next;
  owner_t        owner;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic          done_q;
  logic          pend;
  logic          pend_eff;
  logic          init_fin;
  logic          frame_fin;
  logic          tmo;
  logic          reinit_due;

  // A host request in the deciding cycle counts as already pending.
  assign pend_eff   = pend | reinitReq;
  assign reinit_due = frame_fin && (REINIT_FRAMES != 0) && (frameCount + 16'd1 == REINIT_AT);

  always_comb begin
    state_next    = state;
    guard_to_next = guard_to;
    owner         = OWN_NONE;
    initStart     = 1'b0;
    frameGrant    = 1'b0;
    ready         = 1'b0;
    init_fin      = 1'b0;
    frame_fin     = 1'b0;
    tmo           = 1'b0;
    unique case (state)
      ST_INIT_START: begin
        owner      = OWN_INIT;
        initStart  = ~reset;
        state_next = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        owner = OWN_INIT;
        if (initDone && !done_q) begin
          init_fin      = 1'b1;
          state_next    = ST_GUARD;
          guard_to_next = ST_IDLE;
        end else if (tcnt == TIMEOUT_LAST) begin
          tmo           = 1'b1;
          state_next    = ST_GUARD;
          guard_to_next = ST_INIT_START;
        end
      end
      ST_GUARD: begin
        if (gcnt == GUARD_LAST) begin
          state_next = (pend_eff || guard_to == ST_INIT_START) ? ST_INIT_START : ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (pend_eff) begin
          state_next    = ST_GUARD;
          guard_to_next = ST_INIT_START;
        end else if (frameReq) begin
          state_next = ST_FRAME;
        end
      end
      ST_FRAME: begin
        owner      = OWN_FRAME;
        frameGrant = 1'b1;
        if (frameDone) begin
          frame_fin     = 1'b1;
          state_next    = ST_GUARD;
          guard_to_next = ST_IDLE;
        end else if (tcnt == TIMEOUT_LAST) begin
          tmo           = 1'b1;
          state_next    = ST_GUARD;
          guard_to_next = ST_INIT_START;
        end
      end
      default: state_next = ST_INIT_START;
    endcase
  end

  always_ff @(posedge spiClk) begin
    if (reset) begin
      state      <= ST_INIT_START;
      guard_to   <= ST_IDLE;
      gcnt       <= '0;
      tcnt       <= '0;
      done_q     <= 1'b0;
      pend       <= 1'b0;
      errTimeout <= 1'b0;
      frameCount <= '0;
    end else begin
      state    <= state_next;
      guard_to <= guard_to_next;
      done_q   <= initDone;
      if (state_next != state) begin
        gcnt <= '0;
        tcnt <= '0;
      end else begin
        if (state == ST_GUARD) gcnt <= gcnt + 1'b1;
        if (state == ST_INIT_WAIT || state == ST_FRAME) tcnt <= tcnt + 1'b1;
      end
      // Starting an init satisfies every request seen up to that point.
      if (state_next == ST_INIT_START && state != ST_INIT_START) pend <= 1'b0;
      else if (reinitReq || reinit_due) pend <= 1'b1;
      if (tmo) errTimeout <= 1'b1;
      if (init_fin) frameCount <= '0;
      else if (frame_fin) frameCount <= frameCount + 16'd1;
    end
  end

  led_bus_mux u_mux (
    .spiClk    (spiClk),
    .reset     (reset),
    .owner     (owner),
    .initLat   (initLat),
    .initSdo   (initSdo),
    .initSclk  (initSclk),
    .frameLat  (frameLat),
    .frameSdo  (frameSdo),
    .frameSclk (frameSclk),
    .LAT       (LAT),
    .SDOsingle (SDOsingle),
    .SCLK      (SCLK)
  );

endmodule

// File: tb/tb_led_bus_sequencer.sv
// Directed bench for led_bus_sequencer: init hand-off, frame grants, guard gaps,
// automatic and host re-init, timeout recovery and mid-transfer reset.
module tb_led_bus_sequencer;

  logic        spiClk = 1'b0;
  logic        reset;
  logic        initStart;
  logic        initDone;
  logic        initLat, initSdo, initSclk;
  logic        frameReq, frameGrant, frameDone;
  logic        frameLat, frameSdo, frameSclk;
  logic        reinitReq;
  logic        LAT, SDOsingle, SCLK;
  logic        ready, errTimeout;
  logic [15:0] frameCount;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cd    = -1;

  led_bus_sequencer #(
    .REINIT_FRAMES  (3),
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .spiClk     (spiClk),
    .reset      (reset),
    .initStart  (initStart),
    .initDone   (initDone),
    .initLat    (initLat),
    .initSdo    (initSdo),
    .initSclk   (initSclk),
    .frameReq   (frameReq),
    .frameGrant (frameGrant),
    .frameDone  (frameDone),
    .frameLat   (frameLat),
    .frameSdo   (frameSdo),
    .frameSclk  (frameSclk),
    .reinitReq  (reinitReq),
    .LAT        (LAT),
    .SDOsingle  (SDOsingle),
    .SCLK       (SCLK),
    .ready      (ready),
    .errTimeout (errTimeout),
    .frameCount (frameCount)
  );

  always #5 spiClk = ~spiClk;

  // Init engine model: initDone rises 100 cycles after the initStart cycle.
  initial begin
    initDone = 1'b0;
    forever begin
      @(posedge spiClk);
      #2;
      if (initStart) begin
        initDone = 1'b0;
        cd = 100;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          initDone = 1'b1;
          cd = -1;
        end
      end
    end
  end

  function automatic logic [2:0] bus();
    return {LAT, SDOsingle, SCLK};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge spiClk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
    cyc = 1;
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!ready && w < 400) begin
      tick();
      w++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic do_frame(input string tag, input int len, input int exp_wait,
                          input int reinit_at, input logic [15:0] exp_count,
                          input logic exp_reinit);
    int w;
    logic [2:0] drv;
    w = 0;
    frameReq = 1'b1;
    while (!frameGrant && w < 400) begin
      tick();
      w++;
    end
    chk({tag, "_grant"}, frameGrant, 1);
    chk({tag, "_latency"}, w, exp_wait);
    chk({tag, "_after_init"}, initDone, 1);
    frameReq = 1'b0;
    for (int k = 0; k < len; k++) begin
      drv = {k == len - 1, k[2], k[0]};
      {frameLat, frameSdo, frameSclk} = drv;
      frameDone = (k == len - 1);
      reinitReq = (k == reinit_at);
      tick();
      chk({tag, "_pin"}, bus(), drv);
      chk({tag, "_hold"}, frameGrant, k < len - 1);
    end
    frameDone = 1'b0;
    reinitReq = 1'b0;
    {frameLat, frameSdo, frameSclk} = 3'b111;
    chk({tag, "_count"}, frameCount, exp_count);
    for (int j = 2; j <= 5; j++) begin
      tick();
      chk({tag, "_guard_bus"}, bus(), 0);
      chk({tag, "_guard_grant"}, frameGrant, 0);
    end
    chk({tag, "_next_ready"}, ready, !exp_reinit);
    chk({tag, "_next_init"}, initStart, exp_reinit);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    frameReq  = 1'b0;
    frameDone = 1'b0;
    reinitReq = 1'b0;
    {initLat, initSdo, initSclk}    = 3'b101;
    {frameLat, frameSdo, frameSclk} = 3'b111;
    repeat (3) tick();
    chk("rst_initStart", initStart, 0);
    chk("rst_grant", frameGrant, 0);
    chk("rst_bus", bus(), 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", errTimeout, 0);
    chk("rst_count", frameCount, 0);

    // Power-up init: initStart in cycle 1, ready 100+4+1 cycles later.
    release_reset();
    chk("init_pulse", initStart, 1);
    tick();
    chk("init_pulse_end", initStart, 0);
    run_to(50);
    chk("init_bus", bus(), 3'b101);
    chk("init_not_ready", ready, 0);
    run_to(103);
    chk("init_guard_bus", bus(), 0);
    run_to(105);
    chk("init_guard_ready", ready, 0);
    chk("init_guard_bus2", bus(), 0);
    run_to(106);
    chk("init_ready", ready, 1);
    chk("init_count", frameCount, 0);

    // Back-to-back frames; the third reaches the re-init interval of 3.
    do_frame("f1", 50, 1, -1, 16'd1, 1'b0);
    do_frame("f2", 50, 1, -1, 16'd2, 1'b0);
    do_frame("f3", 50, 1, -1, 16'd3, 1'b1);
    wait_ready("auto_reinit_ready");
    chk("auto_reinit_count", frameCount, 0);

    // Host re-init mid-frame: frame completes, next request waits out the init.
    do_frame("f4", 40, 1, 20, 16'd1, 1'b1);
    do_frame("f5", 30, 106, -1, 16'd1, 1'b0);

    // Host re-init coincident with frameDone: exactly one init follows.
    do_frame("f6", 30, 1, 29, 16'd2, 1'b1);
    wait_ready("f6_init_ready");
    chk("f6_init_count", frameCount, 0);
    n = 0;
    repeat (12) begin
      tick();
      if (initStart) n++;
    end
    chk("single_reinit", n, 0);

    // Stray frameDone in IDLE is ignored.
    frameDone = 1'b1;
    tick();
    frameDone = 1'b0;
    chk("stray_done_count", frameCount, 0);
    chk("stray_done_ready", ready, 1);

    // reinitReq and frameReq together in IDLE: init first, frame after.
    reinitReq = 1'b1;
    frameReq  = 1'b1;
    tick();
    reinitReq = 1'b0;
    chk("simul_no_grant", frameGrant, 0);
    do_frame("f7", 20, 110, -1, 16'd1, 1'b0);

    // Hung frame: grant held exactly 1000 cycles, then guard and re-init.
    frameReq = 1'b1;
    n = 0;
    while (!frameGrant && n < 20) begin
      tick();
      n++;
    end
    chk("to_grant", frameGrant, 1);
    chk("to_err_before", errTimeout, 0);
    frameReq = 1'b0;
    n = 1;
    while (frameGrant && n < 1100) begin
      tick();
      n++;
    end
    chk("to_grant_len", n - 1, 1000);
    chk("to_err", errTimeout, 1);
    repeat (3) tick();
    chk("to_guard_bus", bus(), 0);
    chk("to_guard_noinit", initStart, 0);
    tick();
    chk("to_reinit", initStart, 1);
    wait_ready("to_ready");
    chk("to_err_sticky", errTimeout, 1);
    chk("to_count", frameCount, 0);

    // Reset in the middle of a frame.
    frameReq = 1'b1;
    n = 0;
    while (!frameGrant && n < 20) begin
      tick();
      n++;
    end
    chk("rf_grant", frameGrant, 1);
    frameReq = 1'b0;
    repeat (3) tick();
    chk("rf_bus_frame", bus(), 3'b111);
    reset = 1'b1;
    tick();
    chk("rf_bus", bus(), 0);
    chk("rf_grant_drop", frameGrant, 0);
    chk("rf_initStart", initStart, 0);
    chk("rf_err_clear", errTimeout, 0);
    chk("rf_count", frameCount, 0);
    tick();
    release_reset();
    chk("rf_init_pulse", initStart, 1);
    wait_ready("rf_ready");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_bus_sequencer.md
# led_bus_sequencer

Owns the shared LED-driver serial bus (LAT, SDOsingle, SCLK) and sequences it between the init engine (InitLed) and the frame shifter. After reset it launches the init engine, waits for initDone, then grants the bus to frame transfers one at a time. It inserts guard gaps between owners, recovers from hung transfers by timeout, and re-runs init on host request or every REINIT_FRAMES frames.

## Interface
- REINIT_FRAMES, 0: frames between automatic re-inits; 0 disables automatic re-init
- GUARD_CYCLES, 4: idle bus cycles between owners; minimum 1
- TIMEOUT_CYCLES, 65536: maximum cycles an owner may hold the bus
- spiClk  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- initStart  out  1  one-cycle pulse that starts the init engine
- initDone  in  1  init engine done level
- initLat, initSdo, initSclk  in  1 each  init engine bus drive
- frameReq  in  1  frame shifter request level, held until frameGrant
- frameGrant  out  1  high while the frame shifter owns the bus
- frameDone  in  1  one-cycle pulse at the end of a frame transfer
- frameLat, frameSdo, frameSclk  in  1 each  frame shifter bus drive
- reinitReq  in  1  one-cycle host pulse requesting re-init
- LAT, SDOsingle, SCLK  out  1 each  registered bus to the LED drivers
- ready  out  1  high in IDLE only
- errTimeout  out  1  sticky timeout flag, cleared only by reset
- frameCount  out  16  frames completed since the last init; wraps

## Operation
- States: INIT_START, INIT_WAIT, GUARD, IDLE, FRAME, with a registered next-owner for GUARD.
- INIT_START: assert initStart for one cycle, select the init owner, go to INIT_WAIT.
- INIT_WAIT: wait for a rising edge of initDone (registered previous sample is 0, current is 1). A level already high on entry does not count. On the edge, clear frameCount and go to GUARD, then IDLE.
- IDLE:
  - Priority 1: a pending re-init. Go to GUARD, then INIT_START.
  - Priority 2: frameReq. Assert frameGrant, go to FRAME.
- FRAME: frameGrant stays high. On frameDone, increment frameCount, deassert frameGrant and go to GUARD.
  - After GUARD, go to INIT_START if a re-init is pending, otherwise IDLE.
- Re-init pending flag:
  - Set by reinitReq in any state.
  - Set when a frame completes and REINIT_FRAMES≠0 and the frames-since-init count reaches REINIT_FRAMES.
  - Cleared on entry to INIT_START.
  - A frame in progress is never aborted by re-init.
- GUARD: the bus drives 0,0,0 for exactly GUARD_CYCLES cycles; the owner select is "none".
- Timeout:
  - A counter runs in INIT_WAIT and FRAME and is cleared on state entry.
  - Reaching TIMEOUT_CYCLES sets errTimeout, drops frameGrant, and goes to GUARD, then INIT_START.
- Bus mux: owner init, frame or none (0,0,0). The mux output is registered, so all three lines carry an identical 1-cycle delay.
- frameDone outside FRAME and initDone edges outside INIT_WAIT are ignored.

## Timing
- Reset values: initStart=0, frameGrant=0, LAT=SDOsingle=SCLK=0, ready=0, errTimeout=0, frameCount=0. The state is INIT_START, so initStart pulses in the first cycle after reset deasserts.
- Reset asserted mid-transfer aborts immediately: the bus is 0 the next cycle and frameGrant drops the next cycle.
- Grant latency: frameReq high in IDLE gives frameGrant high the next cycle.
- Bus latency: owner input to pin is 1 cycle.
- Release: frameDone in cycle N gives frameGrant=0 at N+1, then GUARD_CYCLES zero cycles, then ready or initStart.
- Simultaneous reinitReq and frameReq in IDLE: re-init wins. frameReq stays pending and is served after init.
- reinitReq in the same cycle as frameDone: one re-init after GUARD.
- frameCount wraps 0xFFFF→0.

## Structure
- Package led_bus_pkg:
  - typedef enum for the state
  - typedef enum for the owner {OWN_NONE, OWN_INIT, OWN_FRAME}
  - defaults for GUARD_CYCLES and TIMEOUT_CYCLES
- One sub-module, led_bus_mux: registered three-line mux selected by owner. Everything else stays in led_bus_sequencer.

## Test plan
- Reset release with an init model that raises initDone 100 cycles after initStart -> initStart pulse in cycle 1; ready rises 100+GUARD_CYCLES+1 cycles later; bus is 0 during GUARD.
- Three back-to-back frameReq, each done after 50 cycles -> three grants separated by 4 zero cycles; frameCount=3; the frame shifter's SCLK pattern appears on the pin delayed by 1 cycle.
- REINIT_FRAMES=2 with four frames -> init reruns after frames 2 and 4; frameCount returns to 0 after each init.
- reinitReq asserted mid-frame -> the frame completes; GUARD, then initStart; frameGrant stays 0 until initDone rises again.
- Frame shifter never pulses frameDone with TIMEOUT_CYCLES=1000 -> grant drops at cycle 1000, errTimeout=1 and stays high, init reruns.
- Reset pulsed during FRAME -> bus lines and frameGrant are 0 the next cycle; initStart pulses after reset deasserts.
